// File: rtl/term_pkg.sv
// Shared fixed-point formats, constants and the multiply helper for term_pipeline.
package term_pkg;

   localparam int Q16_16_W = 32;
   localparam int Q16_16_F = 16;
   localparam int Q2_16_W  = 18;
   localparam int Q2_16_F  = 16;
   localparam int Q26_6_W  = 32;
   localparam int Q26_6_F  = 6;

   localparam logic signed [Q2_16_W-1:0]  ONE_Q2_16         = 18'sh1_0000;
   localparam logic        [Q16_16_W-1:0] OFFSET_128_Q16_16 = 32'h0080_0000;
   localparam logic        [15:0]         COS_INV24         = 16'h0AAB;

   // Full-width signed product, arithmetic right shift (floor), low 64 bits kept.
   function automatic logic signed [63:0] fx_mul(input logic signed [63:0] a,
                                                 input logic signed [63:0] b,
                                                 input int unsigned        sh);
      logic signed [127:0] aw;
      logic signed [127:0] bw;
      logic signed [127:0] prod;
      aw   = a;
      bw   = b;
      prod = (aw * bw) >>> sh;
      return prod[63:0];
   endfunction

endpackage

// File: rtl/term_pipeline_cos_poly.sv
// Four-stage Taylor cosine: c = 1 - t^2/2 + t^4/24 with t = (x - 128) / 128.
module cos_poly
   import term_pkg::*;
#(
   parameter logic [15:0] COS_INV24 = term_pkg::COS_INV24
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        clk_en,
   input  logic [31:0] x,
   output logic [17:0] c
);

   logic signed [32:0]        x_off;
   logic signed [Q2_16_W-1:0] t_p1;
   logic signed [Q2_16_W-1:0] t2_p2;
   logic signed [Q2_16_W-1:0] t4_p3;
   logic signed [Q2_16_W-1:0] h_p3;
   logic signed [Q2_16_W-1:0] c_p4;

   assign x_off = $signed({1'b0, x}) - $signed({1'b0, OFFSET_128_Q16_16});
   assign c     = c_p4;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         t_p1  <= '0;
         t2_p2 <= '0;
         t4_p3 <= '0;
         h_p3  <= '0;
         c_p4  <= '0;
      end else if (clk_en) begin
         // S1: centre and scale x into [-1, 1)
         t_p1  <= 18'(x_off >>> 7);
         // S2
         t2_p2 <= 18'(fx_mul(64'(t_p1), 64'(t_p1), Q2_16_F));
         // S3
         t4_p3 <= 18'(fx_mul(64'(t2_p2), 64'(t2_p2), Q2_16_F));
         h_p3  <= t2_p2 >>> 1;
         // S4
         c_p4  <= ONE_Q2_16 - h_p3 + 18'(fx_mul(64'(t4_p3), 64'(COS_INV24), Q2_16_F));
      end
   end

endmodule

// File: rtl/term_pipeline.sv
// Six-stage evaluator of f(x) = x/2 + x^3 * cos((x - 128)/128); Q16.16 in, Q26.6 out.
module term_pipeline
   import term_pkg::*;
#(
   parameter int          LATENCY   = 6,
   parameter logic [15:0] COS_INV24 = term_pkg::COS_INV24
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        clk_en,
   input  logic [31:0] x,
   output logic [31:0] result
);

   logic [Q16_16_W-1:0]       x_pipe [1:LATENCY-1];
   logic signed [63:0]        x2_p1;
   logic signed [Q26_6_W-1:0] x3_p2;
   logic signed [Q26_6_W-1:0] x3_p3;
   logic signed [Q26_6_W-1:0] x3_p4;
   logic signed [Q26_6_W-1:0] p_p5;
   logic [17:0]               c_p4;

   cos_poly #(
      .COS_INV24 (COS_INV24)
   ) u_cos_poly (
      .clk     (clk),
      .reset_n (reset_n),
      .clk_en  (clk_en),
      .x       (x),
      .c       (c_p4)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 1; i < LATENCY; i++) x_pipe[i] <= '0;
         x2_p1  <= '0;
         x3_p2  <= '0;
         x3_p3  <= '0;
         x3_p4  <= '0;
         p_p5   <= '0;
         result <= '0;
      end else if (clk_en) begin
         x_pipe[1] <= x;
         for (int i = 2; i < LATENCY; i++) x_pipe[i] <= x_pipe[i-1];
         // S1: x^2 kept at full Q32.32
         x2_p1  <= fx_mul(64'(x), 64'(x), 0);
         // S2: x^3 reduced from Q48.48 to Q26.6
         x3_p2  <= 32'(fx_mul(x2_p1, 64'(x_pipe[1]), 3 * Q16_16_F - Q26_6_F));
         // S3/S4: align x^3 with the cosine result
         x3_p3  <= x3_p2;
         x3_p4  <= x3_p3;
         // S5
         p_p5   <= 32'(fx_mul(64'(x3_p4), 64'($signed(c_p4)), Q2_16_F));
         // S6: x/2 in Q26.6 is the Q16.16 value shifted by 11
         result <= p_p5 + (x_pipe[LATENCY-1] >> 11);
      end
   end

endmodule

// File: tb/tb_term_pipeline.sv
// Directed and swept checks of term_pipeline against hand values and a stage model.
module tb_term_pipeline;

   logic        clk;
   logic        reset_n;
   logic        clk_en;
   logic [31:0] x;
   logic [31:0] result;

   int total;
   int bad;

   typedef struct {
      logic [31:0] x;
      logic [31:0] exp;
      int          tol;
   } vec_t;

   vec_t vecs[6];

   term_pipeline dut (
      .clk     (clk),
      .reset_n (reset_n),
      .clk_en  (clk_en),
      .x       (x),
      .result  (result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic edge1();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp, input int tol);
      logic [31:0] d;
      int          ad;
      d  = act - exp;
      ad = $signed(d);
      if (ad < 0) ad = -ad;
      total++;
      if (ad > tol) begin
         bad++;
         $display("FAIL %s: got 0x%08h want 0x%08h (tol %0d)", name, act, exp, tol);
      end
   endtask

   function automatic logic [31:0] model(input logic [31:0] xv);
      longint       xi, t, t2, t4, h, c, x3, p;
      logic [127:0] xe, x3w;
      xi  = xv;
      t   = (xi - 64'sd8388608) >>> 7;
      t2  = (t * t) >>> 16;
      t4  = (t2 * t2) >>> 16;
      h   = t2 >>> 1;
      c   = 65536 - h + ((t4 * 2731) >>> 16);
      xe  = {96'b0, xv};
      x3w = (xe * xe * xe) >> 42;
      x3  = longint'(x3w[63:0]);
      p   = (x3 * c) >>> 16;
      return 32'(p + longint'(xv >> 11));
   endfunction

   logic [31:0] sweep_x   [1005];
   logic [31:0] sweep_exp [1005];

   initial begin
      total = 0;
      bad   = 0;
      vecs[0] = '{32'h0000_0000, 32'h0000_0000, 0};
      vecs[1] = '{32'h0001_0000, 32'h0000_0043, 4};
      vecs[2] = '{32'h0080_0000, 32'h0800_1000, 0};
      vecs[3] = '{32'h0040_0000, 32'h00E0_B200, 4};
      vecs[4] = '{32'h00C0_0000, 32'h17B2_0600, 4};
      vecs[5] = '{32'h0000_0000, 32'h0000_0000, 0};

      reset_n = 1'b0;
      clk_en  = 1'b0;
      x       = '0;
      repeat (2) edge1();
      check("reset_value", result, 32'h0, 0);
      reset_n = 1'b1;

      // Table: each vector held 6 enabled edges; output after 5 still shows the previous one.
      clk_en = 1'b1;
      for (int i = 0; i < 6; i++) begin
         x = vecs[i].x;
         repeat (5) edge1();
         check($sformatf("vec%0d_edge5", i), result,
               (i == 0) ? 32'h0 : vecs[i-1].exp, (i == 0) ? 0 : vecs[i-1].tol);
         edge1();
         check($sformatf("vec%0d_edge6", i), result, vecs[i].exp, vecs[i].tol);
      end

      // Hold: 3 enabled edges, 10 stalled cycles, then 3 more.
      x = 32'h0040_0000;
      repeat (6) edge1();
      check("hold_pre", result, 32'h00E0_B200, 4);
      x = 32'h0080_0000;
      repeat (3) edge1();
      clk_en = 1'b0;
      for (int i = 0; i < 10; i++) begin
         edge1();
         check($sformatf("hold_stall%0d", i), result, 32'h00E0_B200, 4);
      end
      clk_en = 1'b1;
      repeat (2) edge1();
      check("hold_edge5", result, 32'h00E0_B200, 4);
      edge1();
      check("hold_edge6", result, 32'h0800_1000, 0);

      // Asynchronous reset with the pipeline full of x = 128.0.
      #3;
      reset_n = 1'b0;
      #1;
      check("async_reset", result, 32'h0, 0);
      repeat (2) edge1();
      reset_n = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         edge1();
         check($sformatf("post_reset_edge%0d", i), result, 32'h0, 0);
      end
      edge1();
      check("post_reset_edge6", result, 32'h0800_1000, 0);

      // Streaming three back-to-back operands.
      x = 32'h0000_0000;
      edge1();
      x = 32'h0001_0000;
      edge1();
      x = 32'h0080_0000;
      repeat (4) edge1();
      check("stream0", result, 32'h0, 0);
      edge1();
      check("stream1", result, 32'h43, 4);
      edge1();
      check("stream2", result, 32'h0800_1000, 0);

      // Random streaming sweep against the stage model.
      for (int i = 0; i < 1005; i++) begin
         sweep_x[i]   = $urandom_range(32'h00FF_FFFF, 0);
         sweep_exp[i] = model(sweep_x[i]);
      end
      for (int i = 0; i < 1005; i++) begin
         x = sweep_x[i];
         edge1();
         if (i >= 5) check($sformatf("sweep%0d", i - 5), result, sweep_exp[i-5], 4);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
